// File: rtl/soc_system_stream_pkg.sv
// Shared types and helpers for the master-path stream arbiters.
package soc_system_stream_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEF = 32'sd8;

    // Ceiling log2, never below 1 so a channel field always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        if (r < 32'sd1) begin
            r = 32'sd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_system_master_stream_arbiter_if.sv
// Bundle of the source-side and sink-side stream signals around the arbiter.
interface soc_system_master_stream_arbiter_if
    import soc_system_stream_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CH_W    = clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ*DATA_W-1:0] in_data;
    logic [NUM_REQ-1:0]        in_sop;
    logic [NUM_REQ-1:0]        in_eop;
    logic [NUM_REQ-1:0]        in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic [CH_W-1:0]           out_channel;
    logic                      out_ready;
    logic                      busy;

    modport master (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_channel, busy
    );

    modport slave (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_channel, busy
    );

endinterface

// File: rtl/soc_system_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_REQ.
module soc_system_rr_picker
    import soc_system_stream_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CH_W    = clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [CH_W-1:0]    last,
    output logic               any,
    output logic [CH_W-1:0]    idx
);

    int dist_s;
    int best_s;

    // Rank each requester by its distance after 'last'; the nearest one wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        dist_s = 32'sd0;
        best_s = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            dist_s = (j + 2 * NUM_REQ - int'(last) - 1) % NUM_REQ;
            if (req[j] && (dist_s < best_s)) begin
                best_s = dist_s;
                idx    = CH_W'(j);
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/soc_system_master_stream_arbiter.sv
// Round-robin packet arbiter feeding one byte stream, with a registered output stage
// and the source index carried on out_channel.
module soc_system_master_stream_arbiter
    import soc_system_stream_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 16,
    parameter int CH_W      = clog2(NUM_REQ)
)(
    input  logic clk,
    input  logic reset,
    soc_system_master_stream_arbiter_if.master bus
);

    localparam logic [7:0]      LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [CH_W-1:0] LAST_IDX  = CH_W'(NUM_REQ - 1);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [CH_W-1:0]   grant_r;
    logic [CH_W-1:0]   grant_nxt_s;
    logic [CH_W-1:0]   last_grant_r;
    logic [CH_W-1:0]   last_nxt_s;
    logic [7:0]        beat_cnt_r;
    logic [7:0]        beat_nxt_s;
    logic [CH_W-1:0]   pick_idx_s;
    logic              pick_any_s;

    logic              load_en_s;
    logic              acc_s;
    logic              release_s;
    logic [NUM_REQ-1:0] in_ready_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              sel_sop_s;
    logic              sel_eop_s;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_sop_r;
    logic              out_eop_r;
    logic [CH_W-1:0]   out_channel_r;

    soc_system_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .CH_W    (CH_W)
    ) u_picker (
        .req  (bus.in_valid),
        .last (last_grant_r),
        .any  (pick_any_s),
        .idx  (pick_idx_s)
    );

    // in_ready depends only on registers and out_ready, never on in_valid.
    assign load_en_s = !out_valid_r || bus.out_ready;

    // Decode the grant into per-source ready and the selected beat.
    always_comb begin
        in_ready_s = '0;
        sel_data_s = '0;
        sel_sop_s  = 1'b0;
        sel_eop_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r == CH_W'(i)) begin
                in_ready_s[i] = (state_r == XFER) && load_en_s;
                sel_data_s    = bus.in_data[i*DATA_W +: DATA_W];
                sel_sop_s     = bus.in_sop[i];
                sel_eop_s     = bus.in_eop[i];
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign acc_s     = |(in_ready_s & bus.in_valid);
    // An EOP landing on the last allowed beat is one release, not two.
    assign release_s = acc_s && (sel_eop_s || (beat_cnt_r == LAST_BEAT));

    // Next-state logic for the grant FSM.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        last_nxt_s  = last_grant_r;
        beat_nxt_s  = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = XFER;
                    grant_nxt_s = pick_idx_s;
                    beat_nxt_s  = 8'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            XFER: begin
                if (release_s) begin
                    state_nxt_s = IDLE;
                    last_nxt_s  = grant_r;
                    beat_nxt_s  = 8'd0;
                end else if (acc_s) begin
                    beat_nxt_s  = beat_cnt_r + 8'd1;
                end else begin
                    beat_nxt_s  = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Grant FSM registers; last_grant resets so source 0 is first in line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= LAST_IDX;
            beat_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_nxt_s;
            beat_cnt_r   <= beat_nxt_s;
        end
    end

    // Output stage: load on accept, drain on out_ready, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_sop_r     <= 1'b0;
            out_eop_r     <= 1'b0;
            out_channel_r <= '0;
        end else if (acc_s) begin
            out_valid_r   <= 1'b1;
            out_data_r    <= sel_data_s;
            out_sop_r     <= sel_sop_s;
            out_eop_r     <= sel_eop_s;
            out_channel_r <= grant_r;
        end else if (bus.out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_sop     = out_sop_r;
    assign bus.out_eop     = out_eop_r;
    assign bus.out_channel = out_channel_r;
    assign bus.busy        = (state_r == XFER);

endmodule

// File: tb/tb_soc_system_master_stream_arbiter.sv
// Scoreboard bench: a 4-source/MAX_BURST=16 arbiter and a 3-source/MAX_BURST=1 arbiter.
module tb_soc_system_master_stream_arbiter;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic [1:0] ch;
        int         gap;   // cycles since previous output beat, 0 = unchecked
        int         busy;  // expected busy on that cycle, -1 = unchecked
    } exp_t;

    logic clk;
    logic reset;

    soc_system_master_stream_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .CH_W(2)) bus4 ();
    soc_system_master_stream_arbiter_if #(.NUM_REQ(3), .DATA_W(8), .CH_W(2)) bus3 ();

    soc_system_master_stream_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(16), .CH_W(2)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.master)
    );

    soc_system_master_stream_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_BURST(1), .CH_W(2)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t q4 [4][$];
    beat_t q3 [3][$];
    exp_t  sb4 [$];
    exp_t  sb3 [$];
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    last4 = 0;
    int    last3 = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic put4(input int i, input logic [7:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e;
        q4[i].push_back(b);
    endtask

    task automatic put3(input int i, input logic [7:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e;
        q3[i].push_back(b);
    endtask

    task automatic want4(input logic [7:0] d, input logic s, input logic e, input logic [1:0] ch,
                         input int gap, input int busy);
        exp_t x;
        x.data = d; x.sop = s; x.eop = e; x.ch = ch; x.gap = gap; x.busy = busy;
        sb4.push_back(x);
    endtask

    task automatic want3(input logic [7:0] d, input logic s, input logic e, input logic [1:0] ch,
                         input int gap, input int busy);
        exp_t x;
        x.data = d; x.sop = s; x.eop = e; x.ch = ch; x.gap = gap; x.busy = busy;
        sb3.push_back(x);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (q4[i].size() > 0) begin
                bus4.in_valid[i]       = 1'b1;
                bus4.in_data[i*8 +: 8] = q4[i][0].data;
                bus4.in_sop[i]         = q4[i][0].sop;
                bus4.in_eop[i]         = q4[i][0].eop;
            end else begin
                bus4.in_valid[i]       = 1'b0;
                bus4.in_data[i*8 +: 8] = 8'h00;
                bus4.in_sop[i]         = 1'b0;
                bus4.in_eop[i]         = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (q3[i].size() > 0) begin
                bus3.in_valid[i]       = 1'b1;
                bus3.in_data[i*8 +: 8] = q3[i][0].data;
                bus3.in_sop[i]         = q3[i][0].sop;
                bus3.in_eop[i]         = q3[i][0].eop;
            end else begin
                bus3.in_valid[i]       = 1'b0;
                bus3.in_data[i*8 +: 8] = 8'h00;
                bus3.in_sop[i]         = 1'b0;
                bus3.in_eop[i]         = 1'b0;
            end
        end
    endtask

    // One clock: sample on the falling edge, advance sources just after the rising edge.
    task automatic tick();
        logic [3:0] a4;
        logic [2:0] a3;
        exp_t x;
        @(negedge clk);
        cyc++;
        a4 = bus4.in_valid & bus4.in_ready;
        a3 = bus3.in_valid & bus3.in_ready;
        check_value("in_ready_onehot4", ($countones(bus4.in_ready) <= 1), 1);
        if (bus4.out_valid && bus4.out_ready) begin
            check_value("dut4_beat_expected", (sb4.size() > 0), 1);
            if (sb4.size() > 0) begin
                x = sb4.pop_front();
                check_value("dut4_beat", {bus4.out_channel, bus4.out_sop, bus4.out_eop, bus4.out_data},
                            {x.ch, x.sop, x.eop, x.data});
                if (x.gap > 0) check_value("dut4_gap", cyc - last4, x.gap);
                if (x.busy >= 0) check_value("dut4_busy", bus4.busy, x.busy);
            end
            last4 = cyc;
        end
        if (bus3.out_valid && bus3.out_ready) begin
            check_value("dut3_beat_expected", (sb3.size() > 0), 1);
            if (sb3.size() > 0) begin
                x = sb3.pop_front();
                check_value("dut3_beat", {bus3.out_channel, bus3.out_sop, bus3.out_eop, bus3.out_data},
                            {x.ch, x.sop, x.eop, x.data});
                if (x.gap > 0) check_value("dut3_gap", cyc - last3, x.gap);
                if (x.busy >= 0) check_value("dut3_busy", bus3.busy, x.busy);
            end
            last3 = cyc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (a4[i]) void'(q4[i].pop_front());
        for (int i = 0; i < 3; i++) if (a3[i]) void'(q3[i].pop_front());
        drive();
    endtask

    function automatic int pending();
        int n;
        n = sb4.size() + sb3.size();
        for (int i = 0; i < 4; i++) n += q4[i].size();
        for (int i = 0; i < 3; i++) n += q3[i].size();
        return n;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (pending() > 0 && n < budget) begin
            tick();
            n++;
        end
        check_value(tag, pending(), 0);
        tick();
        tick();
    endtask

    task automatic flush();
        sb4.delete();
        sb3.delete();
        for (int i = 0; i < 4; i++) q4[i].delete();
        for (int i = 0; i < 3; i++) q3[i].delete();
        drive();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flush();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        bus4.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        flush();
        #1;
        tick();
        check_value("rst_out_valid", bus4.out_valid, 0);
        check_value("rst_outputs", {bus4.out_channel, bus4.out_sop, bus4.out_eop, bus4.out_data}, 0);
        check_value("rst_busy", bus4.busy, 0);
        check_value("rst_in_ready", bus4.in_ready, 0);
        tick();
        reset = 1'b0;

        // Two 3-beat packets, sources 0 and 2.
        for (int k = 0; k < 3; k++) begin
            put4(0, 8'hA0 + 8'(k), (k == 0), (k == 2));
            put4(2, 8'hC0 + 8'(k), (k == 0), (k == 2));
        end
        want4(8'hA0, 1'b1, 1'b0, 2'd0, 0, 1);
        want4(8'hA1, 1'b0, 1'b0, 2'd0, 1, 1);
        want4(8'hA2, 1'b0, 1'b1, 2'd0, 1, 0);
        want4(8'hC0, 1'b1, 1'b0, 2'd2, 2, 1);
        want4(8'hC1, 1'b0, 1'b0, 2'd2, 1, 1);
        want4(8'hC2, 1'b0, 1'b1, 2'd2, 1, 0);
        drive();
        drain("t1_drain", 60);

        // Everyone valid with single-beat packets: 0,1,2,3,0,1 at one beat per two cycles.
        apply_reset();
        put4(0, 8'h10, 1'b1, 1'b1); put4(0, 8'h20, 1'b1, 1'b1);
        put4(1, 8'h11, 1'b1, 1'b1); put4(1, 8'h21, 1'b1, 1'b1);
        put4(2, 8'h12, 1'b1, 1'b1);
        put4(3, 8'h13, 1'b1, 1'b1);
        want4(8'h10, 1'b1, 1'b1, 2'd0, 0, 0);
        want4(8'h11, 1'b1, 1'b1, 2'd1, 2, 0);
        want4(8'h12, 1'b1, 1'b1, 2'd2, 2, 0);
        want4(8'h13, 1'b1, 1'b1, 2'd3, 2, 0);
        want4(8'h20, 1'b1, 1'b1, 2'd0, 2, 0);
        want4(8'h21, 1'b1, 1'b1, 2'd1, 2, 0);
        drive();
        drain("t2_drain", 60);

        // 20-beat packet on source 1 split at 16 beats, source 3 interleaves.
        apply_reset();
        for (int k = 0; k < 20; k++) put4(1, 8'h40 + 8'(k), (k == 0), (k == 19));
        put4(3, 8'hE0, 1'b1, 1'b0);
        put4(3, 8'hE1, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++)
            want4(8'h40 + 8'(k), (k == 0), 1'b0, 2'd1, (k == 0) ? 0 : 1, (k == 15) ? 0 : 1);
        want4(8'hE0, 1'b1, 1'b0, 2'd3, 2, 1);
        want4(8'hE1, 1'b0, 1'b1, 2'd3, 1, 0);
        for (int k = 16; k < 20; k++)
            want4(8'h40 + 8'(k), 1'b0, (k == 19), 2'd1, (k == 16) ? 2 : 1, (k == 19) ? 0 : 1);
        drive();
        drain("t3_drain", 120);

        // Five-cycle stall after three beats; the burst split point must not move.
        for (int k = 0; k < 17; k++) put4(0, 8'h60 + 8'(k), (k == 0), (k == 16));
        put4(1, 8'h7F, 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) want4(8'h60 + 8'(k), (k == 0), 1'b0, 2'd0, 0, -1);
        want4(8'h7F, 1'b1, 1'b1, 2'd1, 0, -1);
        want4(8'h70, 1'b0, 1'b1, 2'd0, 0, -1);
        drive();
        n = 0;
        while (sb4.size() > 15 && n < 40) begin
            tick();
            n++;
        end
        check_value("t4_stall_setup", sb4.size(), 15);
        bus4.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check_value("t4_hold_valid", bus4.out_valid, 1);
            check_value("t4_hold_data", bus4.out_data, 8'h63);
            check_value("t4_hold_in_ready", bus4.in_ready, 0);
        end
        bus4.out_ready = 1'b1;
        drain("t4_drain", 120);

        // Reset in the middle of a packet on source 2.
        for (int k = 0; k < 6; k++) put4(2, 8'h90 + 8'(k), (k == 0), (k == 5));
        for (int k = 0; k < 6; k++) want4(8'h90 + 8'(k), (k == 0), (k == 5), 2'd2, 0, -1);
        drive();
        n = 0;
        while (sb4.size() > 4 && n < 40) begin
            tick();
            n++;
        end
        check_value("t5_mid_packet", sb4.size(), 4);
        reset = 1'b1;
        #1;
        check_value("t5_rst_out_valid", bus4.out_valid, 0);
        check_value("t5_rst_outputs", {bus4.out_channel, bus4.out_sop, bus4.out_eop, bus4.out_data}, 0);
        check_value("t5_rst_busy", bus4.busy, 0);
        check_value("t5_rst_in_ready", bus4.in_ready, 0);
        flush();
        tick();
        reset = 1'b0;
        put4(3, 8'hB3, 1'b1, 1'b1);
        put4(2, 8'hB2, 1'b1, 1'b1);
        put4(0, 8'hB0, 1'b1, 1'b1);
        want4(8'hB0, 1'b1, 1'b1, 2'd0, 0, 0);
        want4(8'hB2, 1'b1, 1'b1, 2'd2, 2, 0);
        want4(8'hB3, 1'b1, 1'b1, 2'd3, 2, 0);
        drive();
        drain("t5_drain", 60);

        // Three sources, MAX_BURST=1: wrap from 2 back to 0, one beat per grant.
        put3(0, 8'hD0, 1'b1, 1'b0);
        put3(0, 8'hD1, 1'b0, 1'b1);
        put3(2, 8'hD2, 1'b1, 1'b1);
        put3(2, 8'hD3, 1'b1, 1'b1);
        want3(8'hD0, 1'b1, 1'b0, 2'd0, 0, 0);
        want3(8'hD2, 1'b1, 1'b1, 2'd2, 2, 0);
        want3(8'hD1, 1'b0, 1'b1, 2'd0, 2, 0);
        want3(8'hD3, 1'b1, 1'b1, 2'd2, 2, 0);
        drive();
        drain("t6_drain", 60);

        // Lone requester that was also the last grant is re-granted after one idle cycle.
        put4(3, 8'hF0, 1'b1, 1'b1);
        put4(3, 8'hF1, 1'b1, 1'b1);
        want4(8'hF0, 1'b1, 1'b1, 2'd3, 0, 0);
        want4(8'hF1, 1'b1, 1'b1, 2'd3, 2, 0);
        drive();
        drain("t7_drain", 60);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
